// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// Owns the PC, fetches over a req/ack instruction-memory handshake, and
// applies the control unit's stall, flush and redirect requests.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  REQ   | request outstanding at PC, waiting for / consuming the ack
//  HOLD  | fetched word parked in the hold buffer while the pipe stalls
//  DRAIN | redirect arrived before the ack; waiting to discard the
//        | orphaned fetch, new target already saved in PC
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcWrite,
  input  logic        ifidWrite,
  input  logic        ifidFlush,
  input  logic        pcSrc,
  input  logic        jORb,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_INS,
  output logic [31:0] ID_PC4,
  output logic        ID_valid,
  output logic        fetch_busy
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] hold_ins_q, hold_ins_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] id_ins_q, id_ins_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;

  logic        adv;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] target;

  // Redirect targets are computed from the instruction sitting in IF/ID.
  always_comb begin
    adv      = pcWrite & ifidWrite;
    redirect = pcSrc;
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{id_ins_q[15]}}, id_ins_q[15:0], 2'b00};
    br_tgt   = id_pc4_q + br_off;
    j_tgt    = {id_pc4_q[31:28], id_ins_q[25:0], 2'b00};
    target   = jORb ? br_tgt : j_tgt;
  end

  // Next-state logic for the fetch FSM, PC, hold buffer and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    hold_ins_d   = hold_ins_q;
    hold_pc4_d   = hold_pc4_q;
    id_ins_d     = id_ins_q;
    id_pc4_d     = id_pc4_q;
    id_valid_d   = id_valid_q;

    case (state_q)
      ST_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d = target;
          end else if (adv) begin
            id_ins_d   = imem_rdata;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
            pc_d       = pc_plus4;
          end else begin
            hold_ins_d = imem_rdata;
            hold_pc4_d = pc_plus4;
            state_d    = ST_HOLD;
          end
        end else begin
          // The memory is still working on the old address, so remember it
          // for imem_addr while PC already carries the new target.
          if (redirect) begin
            drain_addr_d = pc_q;
            pc_d         = target;
            state_d      = ST_DRAIN;
          end
          if (ifidWrite) begin
            id_ins_d   = BUBBLE;
            id_valid_d = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = ST_REQ;
        end else if (adv) begin
          id_ins_d   = hold_ins_q;
          id_pc4_d   = hold_pc4_q;
          id_valid_d = 1'b1;
          pc_d       = hold_pc4_q;
          state_d    = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (redirect) pc_d = target;
        if (imem_ack) state_d = ST_REQ;
        // Nothing real is available to ID while draining.
        if (ifidWrite) begin
          id_ins_d   = BUBBLE;
          id_valid_d = 1'b0;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // Flush wins over any IF/ID load; the PC+4 tag is left untouched.
    if (ifidFlush) begin
      id_ins_d   = BUBBLE;
      id_pc4_d   = id_pc4_q;
      id_valid_d = 1'b0;
    end
  end

  // State and pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      hold_ins_q   <= BUBBLE;
      hold_pc4_q   <= 32'h0000_0000;
      id_ins_q     <= BUBBLE;
      id_pc4_q     <= 32'h0000_0000;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      hold_ins_q   <= hold_ins_d;
      hold_pc4_q   <= hold_pc4_d;
      id_ins_q     <= id_ins_d;
      id_pc4_q     <= id_pc4_d;
      id_valid_q   <= id_valid_d;
    end
  end

  // Memory-side and ID-side outputs; the request is forced low during reset.
  always_comb begin
    imem_req   = rst & (state_q != ST_HOLD);
    imem_addr  = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    fetch_busy = ((state_q == ST_REQ) & ~imem_ack) | (state_q == ST_DRAIN);
    ID_INS     = id_ins_q;
    ID_PC4     = id_pc4_q;
    ID_valid   = id_valid_q;
  end

endmodule
